// File: rtl/nyq_cfg_ctrl.sv
// Configuration sequencer for the NYQ Nyquist filter: streams host coefficient
// bursts into the coefficient memory, gates the sample path, then flushes it.
module nyq_cfg_ctrl #(
  parameter int ADDR_WIDTH   = 5,
  parameter int MEM_WIDTH    = 32,
  parameter int NUM_COEFF    = 32,
  parameter int FLUSH_CYCLES = 32
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RI,
  input  logic                  Start_SI,
  input  logic [ADDR_WIDTH-1:0] Base_DI,
  input  logic [ADDR_WIDTH:0]   Len_DI,
  input  logic                  Cfg_Valid_SI,
  input  logic [MEM_WIDTH-1:0]  Cfg_Data_DI,
  output logic                  Cfg_Ready_SO,
  input  logic                  Abort_SI,
  output logic                  WrEn_SO,
  output logic [ADDR_WIDTH-1:0] Addr_DO,
  output logic [MEM_WIDTH-1:0]  PAR_Out_DO,
  output logic                  Smp_En_SO,
  output logic                  Smp_Zero_SO,
  output logic                  Busy_SO,
  output logic                  Done_SO,
  output logic                  Err_SO
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [ADDR_WIDTH+1:0] NUM_C      = (ADDR_WIDTH+2)'(NUM_COEFF);
  localparam logic [CW-1:0]         FLUSH_LAST = CW'(FLUSH_CYCLES - 1);
  localparam logic [CW-1:0]         CNT_ONE    = CW'(1);
  localparam logic [ADDR_WIDTH:0]   IDX_ONE    = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FLUSH, ST_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [CW-1:0]         flush_cnt_q, flush_cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MEM_WIDTH-1:0]  data_q, data_d;
  logic                  err_q, err_d;

  logic [ADDR_WIDTH+1:0] req_end;
  logic                  req_ok;
  logic [ADDR_WIDTH:0]   idx_inc;

  // Legality is checked once at Start so the address adder never wraps in LOAD.
  assign req_end = {2'b00, Base_DI} + {1'b0, Len_DI};
  assign req_ok  = (Len_DI != '0) && ({1'b0, Len_DI} <= NUM_C) && (req_end <= NUM_C);
  assign idx_inc = idx_q + IDX_ONE;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    flush_cnt_d = flush_cnt_q;
    wr_en_d     = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (Start_SI) begin
          if (req_ok) begin
            base_d  = Base_DI;
            len_d   = Len_DI;
            idx_d   = '0;
            err_d   = 1'b0;
            state_d = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        // Abort wins over a coincident handshake: that word is dropped.
        if (Abort_SI) begin
          err_d       = 1'b1;
          flush_cnt_d = '0;
          state_d     = ST_FLUSH;
        end else if (Cfg_Valid_SI) begin
          wr_en_d = 1'b1;
          addr_d  = base_q + idx_q[ADDR_WIDTH-1:0];
          data_d  = Cfg_Data_DI;
          idx_d   = idx_inc;
          if (idx_inc == len_q) begin
            flush_cnt_d = '0;
            state_d     = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d = ST_DONE;
        end else begin
          flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      flush_cnt_q <= '0;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      flush_cnt_q <= flush_cnt_d;
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      err_q       <= err_d;
    end
  end

  // Handshake: a word transfers on any cycle with Cfg_Valid_SI & Cfg_Ready_SO & !Abort_SI.
  assign Cfg_Ready_SO = (state_q == ST_LOAD);
  assign Smp_En_SO    = (state_q != ST_LOAD);
  assign Smp_Zero_SO  = (state_q == ST_FLUSH);
  assign Busy_SO      = (state_q != ST_IDLE);
  assign Done_SO      = (state_q == ST_DONE);
  assign WrEn_SO      = wr_en_q;
  assign Addr_DO      = addr_q;
  assign PAR_Out_DO   = data_q;
  assign Err_SO       = err_q;

endmodule

// File: doc/nyq_cfg_ctrl.md
Name: nyq_cfg_ctrl

Overview:
Configuration sequencer for the NYQ Nyquist filter block. It accepts coefficient bursts from a host over a valid/ready stream and drives the NYQ coefficient-memory write port (WrEn/Addr/PAR_In) with one write per cycle. It gates the NYQ sample path while coefficients are being rewritten, then flushes the filter delay line with zero samples before releasing normal traffic.

Parameters:
ADDR_WIDTH, 5, coefficient memory address bits
MEM_WIDTH, 32, coefficient word width
NUM_COEFF, 32, number of coefficient locations (legal addresses 0..NUM_COEFF-1)
FLUSH_CYCLES, 32, zero-sample cycles issued after a load (min 1)

Ports:
Clk_CI  in  1  clock
Rst_RI  in  1  reset, asynchronous, active-high
Start_SI  in  1  load request, sampled in IDLE only
Base_DI  in  ADDR_WIDTH  first coefficient address
Len_DI  in  ADDR_WIDTH+1  number of words in the burst
Cfg_Valid_SI  in  1  host data valid
Cfg_Data_DI  in  MEM_WIDTH  host coefficient word
Cfg_Ready_SO  out  1  controller ready for a host word
Abort_SI  in  1  abort the current load
WrEn_SO  out  1  NYQ coefficient write enable
Addr_DO  out  ADDR_WIDTH  NYQ coefficient address
PAR_Out_DO  out  MEM_WIDTH  NYQ coefficient write data
Smp_En_SO  out  1  NYQ sample path enabled
Smp_Zero_SO  out  1  force zero NYQ input samples
Busy_SO  out  1  high in every state except IDLE
Done_SO  out  1  one-cycle completion pulse
Err_SO  out  1  sticky error flag

Behaviour:
- Reset (asynchronous, Rst_RI=1): state=IDLE, all counters 0. Output values: WrEn_SO=0, Addr_DO=0, PAR_Out_DO=0, Cfg_Ready_SO=0, Smp_En_SO=1, Smp_Zero_SO=0, Busy_SO=0, Done_SO=0, Err_SO=0. Asserting reset mid-burst cancels the burst with no further write.
- All outputs are registered or decoded from the state register only. They are glitch-free, with no combinational path from inputs.
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE:
  - Smp_En=1, Smp_Zero=0, Ready=0.
  - Start_SI=1 with 1 <= Len_DI <= NUM_COEFF and Base_DI+Len_DI <= NUM_COEFF: latch Base and Len, clear idx and Err, go to LOAD.
  - Start_SI=1 with an illegal Len or Base: set Err_SO=1 next cycle, stay in IDLE, no write.
- LOAD:
  - Ready=1, Smp_En=0, Busy=1.
  - A handshake (Valid & Ready) in cycle k gives WrEn_SO=1, Addr_DO=Base+idx, PAR_Out_DO=Cfg_Data_DI in cycle k+1, then idx increments.
  - Cycles without a handshake give WrEn_SO=0; Addr/Data hold their last value.
  - The handshake with idx=Len-1 moves the state to FLUSH; Ready is low from the next cycle.
  - Addr arithmetic is ADDR_WIDTH-bit and never wraps, because legality is checked at Start.
- LOAD abort: Abort_SI=1 in LOAD sets Err_SO=1 and goes to FLUSH.
  - A handshake in the same cycle as Abort is not accepted: Ready is treated as 0 and no write follows.
  - Writes already performed remain in memory.
- FLUSH:
  - Smp_En=1, Smp_Zero=1, Ready=0 for exactly FLUSH_CYCLES cycles, then DONE.
  - The final LOAD write appears in the first FLUSH cycle.
  - Abort_SI is ignored in FLUSH.
- DONE: a single cycle with Done_SO=1, Smp_En=1, Smp_Zero=0, Busy=1; the next state is IDLE.
- Start_SI is ignored in LOAD, FLUSH and DONE. Err_SO clears only on the next accepted Start.
- Latency, for a Start at cycle 0 with Valid held high:
  - Writes occur in cycles 2..L+1.
  - FLUSH runs in cycles L+1..L+FLUSH_CYCLES.
  - Done pulses in cycle L+FLUSH_CYCLES+1.
  - Busy drops in cycle L+FLUSH_CYCLES+2.

Test Plan:
- Full load: Base=0, Len=32, Valid held high, Data=0x1000+i -> 32 writes in cycles 2..33 at addresses 0..31 with data 0x1000..0x101F; Smp_Zero=1 in cycles 33..64; Done=1 at cycle 65 only; Err=0.
- Bubbles: Base=10, Len=4, Valid on alternate cycles -> exactly 4 writes at addresses 10..13, each one cycle after its handshake; Ready stays 1 throughout LOAD; Smp_En=0 until the final write cycle.
- Illegal request: Base=30, Len=4 -> Err=1 next cycle, Busy=0, no WrEn. A following legal Start (Base=0, Len=1) clears Err and performs 1 write at address 0.
- Abort: Base=0, Len=8, Abort asserted with the 3rd valid word -> exactly 2 writes (addresses 0, 1), Err=1, 32 FLUSH cycles, then a Done pulse.
- Start while busy: a second Start during LOAD with Base=5 is ignored -> the addresses continue from the first burst's Base; one Done pulse only.
- Async reset during LOAD after 3 writes -> all outputs return to reset values immediately with no clock edge; no write after reset is released; Smp_En=1.
